// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipelined control unit: opcodes, control-word layout
// and a helper that packs the named control fields into a word.
package pipe_ctrl_pkg;

  localparam int unsigned CTRL_W = 9;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_JUMP = 6'b000010;
  localparam logic [5:0] OP_JC   = 6'b000011;
  localparam logic [5:0] OP_JZ   = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_MOVI = 6'b001001;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam int unsigned CB_REGDST   = 8;
  localparam int unsigned CB_ALUSRC   = 7;
  localparam int unsigned CB_MEMTOREG = 6;
  localparam int unsigned CB_REGWRITE = 5;
  localparam int unsigned CB_MEMREAD  = 4;
  localparam int unsigned CB_MEMWRITE = 3;
  localparam int unsigned CB_BRANCH   = 2;
  localparam int unsigned CB_ALUOP    = 0;  // two bits wide, [1:0]

  typedef logic [CTRL_W-1:0] ctrl_t;

  localparam ctrl_t NOP_CTRL = '0;

  function automatic ctrl_t mk_ctrl(logic reg_dst, logic alu_src, logic mem_to_reg,
                                    logic reg_write, logic mem_read, logic mem_write,
                                    logic branch, logic [1:0] alu_op);
    ctrl_t c;
    c = NOP_CTRL;
    c[CB_REGDST]            = reg_dst;
    c[CB_ALUSRC]            = alu_src;
    c[CB_MEMTOREG]          = mem_to_reg;
    c[CB_REGWRITE]          = reg_write;
    c[CB_MEMREAD]           = mem_read;
    c[CB_MEMWRITE]          = mem_write;
    c[CB_BRANCH]            = branch;
    c[CB_ALUOP+1:CB_ALUOP]  = alu_op;
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// ID-stage inputs and pipeline control outputs of the control unit, grouped as one bus.
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W = 6,
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 8
);
  logic             hold;
  logic             id_valid;
  logic [OPC_W-1:0] id_opcode;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             ex_branch_taken;

  logic             pc_write_en;
  logic             if_id_flush;
  ctrl_t            ex_ctrl;
  ctrl_t            mem_ctrl;
  ctrl_t            wb_ctrl;
  logic             ex_valid;
  logic             mem_valid;
  logic             wb_valid;
  logic             illegal_op;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    output hold, id_valid, id_opcode, id_rs, id_rt, ex_branch_taken,
    input  pc_write_en, if_id_flush, ex_ctrl, mem_ctrl, wb_ctrl,
           ex_valid, mem_valid, wb_valid, illegal_op, illegal_cnt
  );

  modport slave (
    input  hold, id_valid, id_opcode, id_rs, id_rt, ex_branch_taken,
    output pc_write_en, if_id_flush, ex_ctrl, mem_ctrl, wb_ctrl,
           ex_valid, mem_valid, wb_valid, illegal_op, illegal_cnt
  );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control word plus an illegal-opcode flag.
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W = 6
) (
  input  logic [OPC_W-1:0] opcode_i,
  output ctrl_t            ctrl_o,
  output logic             illegal_o
);

  always_comb begin
    ctrl_o    = NOP_CTRL;
    illegal_o = 1'b0;
    unique case (opcode_i)
      OPC_W'(OP_R):    ctrl_o = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
      OPC_W'(OP_ADDI),
      OPC_W'(OP_ANDI),
      OPC_W'(OP_ORI),
      OPC_W'(OP_XORI),
      OPC_W'(OP_MOVI): ctrl_o = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      OPC_W'(OP_JUMP): ctrl_o = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
      OPC_W'(OP_JC),
      OPC_W'(OP_JZ):   ctrl_o = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
      OPC_W'(OP_LW):   ctrl_o = mk_ctrl(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
      OPC_W'(OP_SW):   ctrl_o = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
      default:         illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes ID, carries the control word through EX/MEM/WB,
// inserts load-use bubbles, squashes on taken branches and counts illegal opcodes.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W          = 6,
  parameter int unsigned REG_W          = 5,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned LOAD_USE_STALL = 1
) (
  input logic        clk,
  input logic        rst_n,
  pipe_ctrl_if.slave bus
);

  ctrl_t id_ctrl;
  logic  id_illegal;

  ctrl_decode #(
    .OPC_W (OPC_W)
  ) u_decode (
    .opcode_i  (bus.id_opcode),
    .ctrl_o    (id_ctrl),
    .illegal_o (id_illegal)
  );

  ctrl_t            ex_ctrl_q, ex_ctrl_d, mem_ctrl_q, mem_ctrl_d, wb_ctrl_q, wb_ctrl_d;
  logic             ex_valid_q, ex_valid_d, mem_valid_q, mem_valid_d, wb_valid_q, wb_valid_d;
  logic [REG_W-1:0] ex_rt_q, ex_rt_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

  logic load_use, flush, accept, illegal_acc;

  always_comb begin
    load_use = (LOAD_USE_STALL != 0) && ex_valid_q && ex_ctrl_q[CB_MEMREAD] && bus.id_valid &&
               ((ex_rt_q == bus.id_rs) || (ex_rt_q == bus.id_rt));
    flush       = bus.ex_branch_taken && !bus.hold;
    // Flush beats load_use: the dependent instruction is being squashed anyway.
    accept      = !bus.hold && !flush && !load_use;
    illegal_acc = accept && bus.id_valid && id_illegal;
  end

  always_comb begin
    ex_ctrl_d     = ex_ctrl_q;
    ex_valid_d    = ex_valid_q;
    ex_rt_d       = ex_rt_q;
    mem_ctrl_d    = mem_ctrl_q;
    mem_valid_d   = mem_valid_q;
    wb_ctrl_d     = wb_ctrl_q;
    wb_valid_d    = wb_valid_q;
    illegal_cnt_d = illegal_cnt_q;
    if (!bus.hold) begin
      mem_ctrl_d  = ex_ctrl_q;
      mem_valid_d = ex_valid_q;
      wb_ctrl_d   = mem_ctrl_q;
      wb_valid_d  = mem_valid_q;
      if (accept) begin
        ex_ctrl_d  = bus.id_valid ? id_ctrl : NOP_CTRL;
        ex_valid_d = bus.id_valid;
        ex_rt_d    = bus.id_rt;
      end else begin
        ex_ctrl_d  = NOP_CTRL;
        ex_valid_d = 1'b0;
      end
      if (illegal_acc && (illegal_cnt_q != {CNT_W{1'b1}})) begin
        illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_ctrl_q     <= NOP_CTRL;
      mem_ctrl_q    <= NOP_CTRL;
      wb_ctrl_q     <= NOP_CTRL;
      ex_valid_q    <= 1'b0;
      mem_valid_q   <= 1'b0;
      wb_valid_q    <= 1'b0;
      ex_rt_q       <= '0;
      illegal_cnt_q <= '0;
    end else begin
      ex_ctrl_q     <= ex_ctrl_d;
      mem_ctrl_q    <= mem_ctrl_d;
      wb_ctrl_q     <= wb_ctrl_d;
      ex_valid_q    <= ex_valid_d;
      mem_valid_q   <= mem_valid_d;
      wb_valid_q    <= wb_valid_d;
      ex_rt_q       <= ex_rt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  always_comb begin
    bus.pc_write_en = !rst_n || (!bus.hold && (flush || !load_use));
    bus.if_id_flush = rst_n && flush;
    bus.illegal_op  = rst_n && illegal_acc;
    bus.ex_ctrl     = ex_ctrl_q;
    bus.mem_ctrl    = mem_ctrl_q;
    bus.wb_ctrl     = wb_ctrl_q;
    bus.ex_valid    = ex_valid_q;
    bus.mem_valid   = mem_valid_q;
    bus.wb_valid    = wb_valid_q;
    bus.illegal_cnt = illegal_cnt_q;
  end

endmodule
